// File: rtl/dunit_host_ctrl_if.sv
// Handshake bundle between the debug-unit host controller, the UART cores and
// the pipeline's dunit_* debug port.
interface dunit_host_ctrl_if #(
  parameter int NB_REG  = 32,
  parameter int NB_BYTE = 8
);
  logic [NB_BYTE-1:0] i_rx_data;
  logic               i_rx_valid;
  logic [NB_BYTE-1:0] o_tx_data;
  logic               o_tx_start;
  logic               i_tx_done;
  logic               i_halt;
  logic [NB_REG-1:0]  i_dunit_reg;
  logic [NB_REG-1:0]  i_dunit_mem_data;
  logic               o_dunit_clk_en;
  logic               o_dunit_reset_pc;
  logic               o_dunit_w_mem;
  logic [NB_REG-1:0]  o_dunit_addr;
  logic [NB_REG-1:0]  o_dunit_data_if;

  modport master (
    input  i_rx_data, i_rx_valid, i_tx_done, i_halt, i_dunit_reg, i_dunit_mem_data,
    output o_tx_data, o_tx_start, o_dunit_clk_en, o_dunit_reset_pc, o_dunit_w_mem,
           o_dunit_addr, o_dunit_data_if
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_tx_done, i_halt, i_dunit_reg, i_dunit_mem_data,
    input  o_tx_data, o_tx_start, o_dunit_clk_en, o_dunit_reset_pc, o_dunit_w_mem,
           o_dunit_addr, o_dunit_data_if
  );
endinterface

// File: rtl/dunit_host_ctrl.sv
// Debug-unit host controller: decodes single-byte UART commands and drives the
// pipeline debug port (load imem, PC reset, step, run, register/dmem dump).
module dunit_host_ctrl #(
  parameter int NB_REG    = 32,
  parameter int NB_BYTE   = 8,
  parameter int MEM_WORDS = 16,
  parameter int MAX_RUN   = 1024,
  parameter int NB_CNT    = 16
) (
  input  logic            i_clk,
  input  logic            i_reset,
  dunit_host_ctrl_if.master bus
);

  localparam logic [NB_BYTE-1:0] CMD_LOAD  = 8'h4C;
  localparam logic [NB_BYTE-1:0] CMD_PC    = 8'h50;
  localparam logic [NB_BYTE-1:0] CMD_STEP  = 8'h53;
  localparam logic [NB_BYTE-1:0] CMD_RUN   = 8'h52;
  localparam logic [NB_BYTE-1:0] CMD_DUMP  = 8'h44;
  localparam logic [NB_BYTE-1:0] ACK_OK    = 8'h4B;
  localparam logic [NB_BYTE-1:0] ACK_TO    = 8'h54;
  localparam logic [NB_BYTE-1:0] ACK_UNK   = 8'h3F;
  localparam logic [NB_BYTE-1:0] ZERO_BYTE = 8'h00;
  localparam logic [NB_CNT-1:0]  CNT_ONE   = NB_CNT'(32'd1);
  localparam logic [NB_CNT-1:0]  RUN_LAST  = NB_CNT'(MAX_RUN - 32'd1);
  localparam logic [NB_CNT-1:0]  MEM_LAST  = NB_CNT'(MEM_WORDS - 32'd1);
  localparam logic [NB_CNT-1:0]  REG_LAST  = NB_CNT'(32'd31);

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_LOAD_CNT   = 4'd1,
    ST_LOAD_BYTE  = 4'd2,
    ST_LOAD_WRITE = 4'd3,
    ST_PC_RST     = 4'd4,
    ST_STEP       = 4'd5,
    ST_RUN        = 4'd6,
    ST_DUMP_WAIT  = 4'd7,
    ST_DUMP_LATCH = 4'd8,
    ST_DUMP_SEND  = 4'd9,
    ST_DUMP_TXW   = 4'd10,
    ST_ACK_SEND   = 4'd11,
    ST_ACK_WAIT   = 4'd12
  } state_t;

  state_t             state_r, state_nxt;
  logic [NB_BYTE-1:0] tx_data_r, tx_data_nxt;
  logic               tx_start_r, tx_start_nxt;
  logic               clk_en_r, clk_en_nxt;
  logic               reset_pc_r, reset_pc_nxt;
  logic               w_mem_r, w_mem_nxt;
  logic [NB_REG-1:0]  addr_r, addr_nxt;
  logic [NB_REG-1:0]  data_if_r, data_if_nxt;
  logic [NB_BYTE-1:0] load_n_r, load_n_nxt;
  logic [NB_CNT-1:0]  idx_r, idx_nxt;
  logic [1:0]         byte_idx_r, byte_idx_nxt;
  logic [NB_REG-1:0]  word_r, word_nxt;
  logic [NB_CNT-1:0]  run_cnt_r, run_cnt_nxt;
  logic               dump_mem_r, dump_mem_nxt;
  logic [NB_BYTE-1:0] ack_r, ack_nxt;
  logic [NB_REG-1:0]  word_in_s;

  // Byte address of a 32-bit word index.
  function automatic logic [NB_REG-1:0] word_addr(input logic [NB_CNT-1:0] idx);
    word_addr = NB_REG'({idx, 2'b00});
  endfunction

  // Incoming byte shifted into the low end of the assembly word (MSB-first).
  assign word_in_s = {word_r[NB_REG-NB_BYTE-1:0], bus.i_rx_data};

  // Next-state and next-output decode; counters/shift register share word_r/idx_r.
  always_comb begin
    state_nxt    = state_r;
    tx_data_nxt  = tx_data_r;
    tx_start_nxt = 1'b0;
    clk_en_nxt   = 1'b0;
    reset_pc_nxt = 1'b0;
    w_mem_nxt    = 1'b0;
    addr_nxt     = addr_r;
    data_if_nxt  = data_if_r;
    load_n_nxt   = load_n_r;
    idx_nxt      = idx_r;
    byte_idx_nxt = byte_idx_r;
    word_nxt     = word_r;
    run_cnt_nxt  = run_cnt_r;
    dump_mem_nxt = dump_mem_r;
    ack_nxt      = ack_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.i_rx_valid) begin
          case (bus.i_rx_data)
            CMD_LOAD: begin
              state_nxt    = ST_LOAD_CNT;
              reset_pc_nxt = 1'b1;
            end
            CMD_PC: begin
              state_nxt    = ST_PC_RST;
              reset_pc_nxt = 1'b1;
            end
            CMD_STEP: begin
              state_nxt  = ST_STEP;
              clk_en_nxt = 1'b1;
            end
            CMD_RUN: begin
              state_nxt   = ST_RUN;
              clk_en_nxt  = 1'b1;
              run_cnt_nxt = '0;
            end
            CMD_DUMP: begin
              state_nxt    = ST_DUMP_WAIT;
              idx_nxt      = '0;
              dump_mem_nxt = 1'b0;
              addr_nxt     = '0;
            end
            default: begin
              state_nxt = ST_ACK_SEND;
              ack_nxt   = ACK_UNK;
            end
          endcase
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_LOAD_CNT: begin
        reset_pc_nxt = 1'b1;
        if (bus.i_rx_valid) begin
          if (bus.i_rx_data == ZERO_BYTE) begin
            state_nxt    = ST_ACK_SEND;
            ack_nxt      = ACK_OK;
            reset_pc_nxt = 1'b0;
          end else begin
            state_nxt    = ST_LOAD_BYTE;
            load_n_nxt   = bus.i_rx_data;
            idx_nxt      = '0;
            byte_idx_nxt = 2'd0;
          end
        end else begin
          state_nxt = ST_LOAD_CNT;
        end
      end
      ST_LOAD_BYTE: begin
        reset_pc_nxt = 1'b1;
        if (bus.i_rx_valid) begin
          word_nxt = word_in_s;
          if (byte_idx_r == 2'd3) begin
            state_nxt    = ST_LOAD_WRITE;
            w_mem_nxt    = 1'b1;
            addr_nxt     = word_addr(idx_r);
            data_if_nxt  = word_in_s;
            byte_idx_nxt = 2'd0;
          end else begin
            byte_idx_nxt = byte_idx_r + 2'd1;
          end
        end else begin
          state_nxt = ST_LOAD_BYTE;
        end
      end
      ST_LOAD_WRITE: begin
        idx_nxt = idx_r + CNT_ONE;
        if ((idx_r + CNT_ONE) == NB_CNT'(load_n_r)) begin
          state_nxt = ST_ACK_SEND;
          ack_nxt   = ACK_OK;
        end else begin
          state_nxt    = ST_LOAD_BYTE;
          reset_pc_nxt = 1'b1;
        end
      end
      ST_PC_RST: begin
        state_nxt = ST_ACK_SEND;
        ack_nxt   = ACK_OK;
      end
      ST_STEP: begin
        state_nxt = ST_ACK_SEND;
        ack_nxt   = ACK_OK;
      end
      ST_RUN: begin
        // Halt is checked first so it wins over a coincident timeout.
        if (bus.i_halt) begin
          state_nxt = ST_ACK_SEND;
          ack_nxt   = ACK_OK;
        end else if (run_cnt_r == RUN_LAST) begin
          state_nxt = ST_ACK_SEND;
          ack_nxt   = ACK_TO;
        end else begin
          clk_en_nxt  = 1'b1;
          run_cnt_nxt = run_cnt_r + CNT_ONE;
        end
      end
      ST_DUMP_WAIT: begin
        state_nxt = ST_DUMP_LATCH;
      end
      ST_DUMP_LATCH: begin
        state_nxt    = ST_DUMP_SEND;
        byte_idx_nxt = 2'd0;
        if (dump_mem_r) begin
          word_nxt = bus.i_dunit_mem_data;
        end else begin
          word_nxt = bus.i_dunit_reg;
        end
      end
      ST_DUMP_SEND: begin
        state_nxt    = ST_DUMP_TXW;
        tx_data_nxt  = word_r[NB_REG-1 -: NB_BYTE];
        tx_start_nxt = 1'b1;
      end
      ST_DUMP_TXW: begin
        if (bus.i_tx_done) begin
          word_nxt = word_r << NB_BYTE;
          if (byte_idx_r == 2'd3) begin
            if (dump_mem_r && (idx_r == MEM_LAST)) begin
              state_nxt = ST_ACK_SEND;
              ack_nxt   = ACK_OK;
            end else if (!dump_mem_r && (idx_r == REG_LAST)) begin
              state_nxt    = ST_DUMP_WAIT;
              dump_mem_nxt = 1'b1;
              idx_nxt      = '0;
              addr_nxt     = '0;
            end else begin
              state_nxt = ST_DUMP_WAIT;
              idx_nxt   = idx_r + CNT_ONE;
              if (dump_mem_r) begin
                addr_nxt = word_addr(idx_r + CNT_ONE);
              end else begin
                addr_nxt = NB_REG'(idx_r + CNT_ONE);
              end
            end
          end else begin
            state_nxt    = ST_DUMP_SEND;
            byte_idx_nxt = byte_idx_r + 2'd1;
          end
        end else begin
          state_nxt = ST_DUMP_TXW;
        end
      end
      ST_ACK_SEND: begin
        state_nxt    = ST_ACK_WAIT;
        tx_data_nxt  = ack_r;
        tx_start_nxt = 1'b1;
      end
      ST_ACK_WAIT: begin
        if (bus.i_tx_done) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_ACK_WAIT;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_r    <= ST_IDLE;
      tx_data_r  <= '0;
      tx_start_r <= 1'b0;
      clk_en_r   <= 1'b0;
      reset_pc_r <= 1'b0;
      w_mem_r    <= 1'b0;
      addr_r     <= '0;
      data_if_r  <= '0;
      load_n_r   <= '0;
      idx_r      <= '0;
      byte_idx_r <= 2'd0;
      word_r     <= '0;
      run_cnt_r  <= '0;
      dump_mem_r <= 1'b0;
      ack_r      <= '0;
    end else begin
      state_r    <= state_nxt;
      tx_data_r  <= tx_data_nxt;
      tx_start_r <= tx_start_nxt;
      clk_en_r   <= clk_en_nxt;
      reset_pc_r <= reset_pc_nxt;
      w_mem_r    <= w_mem_nxt;
      addr_r     <= addr_nxt;
      data_if_r  <= data_if_nxt;
      load_n_r   <= load_n_nxt;
      idx_r      <= idx_nxt;
      byte_idx_r <= byte_idx_nxt;
      word_r     <= word_nxt;
      run_cnt_r  <= run_cnt_nxt;
      dump_mem_r <= dump_mem_nxt;
      ack_r      <= ack_nxt;
    end
  end

  assign bus.o_tx_data        = tx_data_r;
  assign bus.o_tx_start       = tx_start_r;
  // Halt must stop the pipeline in the very cycle it is seen, hence the gate.
  assign bus.o_dunit_clk_en   = clk_en_r && !((state_r == ST_RUN) && bus.i_halt);
  assign bus.o_dunit_reset_pc = reset_pc_r;
  assign bus.o_dunit_w_mem    = w_mem_r;
  assign bus.o_dunit_addr     = addr_r;
  assign bus.o_dunit_data_if  = data_if_r;

endmodule

// File: tb/tb_dunit_host_ctrl.sv
// Scoreboard bench for dunit_host_ctrl: stimulus pushes expected TX bytes and
// imem writes into queues, monitors pop and compare as the DUT emits them.
module tb_dunit_host_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dunit_host_ctrl_if #(.NB_REG(32), .NB_BYTE(8)) bus ();

  dunit_host_ctrl #(
    .NB_REG(32), .NB_BYTE(8), .MEM_WORDS(16), .MAX_RUN(1024), .NB_CNT(16)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst_n),
    .bus    (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  exp_tx[$];
  logic [63:0] exp_wr[$];
  int          tx_cnt = 0;
  int          ce_cnt = 0;
  int          rpc_cnt = 0;
  int          wr_cnt = 0;
  int          tx_delay = 3;
  bit          tx_busy = 1'b0;
  logic        last_rpc;
  logic        last_ce;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Register file / data memory models with one cycle read latency.
  always @(posedge clk) begin
    bus.i_dunit_reg      <= 32'h0000_0100 + bus.o_dunit_addr;
    bus.i_dunit_mem_data <= 32'hA000_0000 + (bus.o_dunit_addr >> 2);
  end

  // Output monitor: TX bytes and imem writes against the scoreboard queues.
  initial forever begin
    @(negedge clk);
    if (bus.o_tx_start === 1'b1) begin
      tx_cnt++;
      if (exp_tx.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL tx_unexpected: got byte 0x%02h, required no byte", bus.o_tx_data);
      end else begin
        check("tx_byte", {56'd0, bus.o_tx_data}, {56'd0, exp_tx.pop_front()});
      end
    end
    if (bus.o_dunit_clk_en === 1'b1) ce_cnt++;
    if (bus.o_dunit_reset_pc === 1'b1) rpc_cnt++;
    if (bus.o_dunit_w_mem === 1'b1) begin
      wr_cnt++;
      if (exp_wr.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL imem_unexpected: got addr 0x%0h data 0x%0h, required no write",
                 bus.o_dunit_addr, bus.o_dunit_data_if);
      end else begin
        check("imem_write", {bus.o_dunit_addr, bus.o_dunit_data_if}, exp_wr.pop_front());
      end
      check("write_ctl_rpc_ce", {62'd0, bus.o_dunit_reset_pc, bus.o_dunit_clk_en}, 64'd2);
    end
  end

  // UART TX model: raises i_tx_done tx_delay cycles after each start.
  initial begin
    logic [7:0] held;
    bus.i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.o_tx_start === 1'b1) begin
        held = bus.o_tx_data;
        tx_busy = 1'b1;
        for (int k = 0; k < tx_delay; k++) begin
          @(negedge clk);
          if (bus.o_tx_start === 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL tx_overlap: got start before done, required none");
          end
        end
        check("tx_hold", {56'd0, bus.o_tx_data}, {56'd0, held});
        bus.i_tx_done = 1'b1;
        @(negedge clk);
        bus.i_tx_done = 1'b0;
        tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    @(negedge clk);
    bus.i_rx_valid = 1'b0;
    last_rpc = bus.o_dunit_reset_pc;
    last_ce  = bus.o_dunit_clk_en;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int i = 0;
    while ((i < budget) && ((exp_tx.size() != 0) || tx_busy)) begin
      @(posedge clk);
      #2;
      i++;
    end
    check(name, 64'(exp_tx.size()), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [31:0] ld_words [3];
    int base_tx, base_ce, base_rpc, base_wr, viol, guard;
    ld_words[0] = 32'h2003_0001;
    ld_words[1] = 32'h2064_0002;
    ld_words[2] = 32'h2085_0003;
    bus.i_rx_data  = 8'h00;
    bus.i_rx_valid = 1'b0;
    bus.i_halt     = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_ctl", {60'd0, bus.o_tx_start, bus.o_dunit_clk_en, bus.o_dunit_reset_pc,
                        bus.o_dunit_w_mem}, 64'd0);
    check("reset_addr_data", {bus.o_dunit_addr, bus.o_dunit_data_if}, 64'd0);
    check("reset_tx_data", {56'd0, bus.o_tx_data}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: reset in the middle of a load
    base_tx = tx_cnt;
    send_rx(8'h4C); send_rx(8'd2); send_rx(8'h11); send_rx(8'h22); send_rx(8'h33);
    check("midload_rpc", {63'd0, bus.o_dunit_reset_pc}, 64'd1);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    check("midload_reset_ctl", {60'd0, bus.o_tx_start, bus.o_dunit_clk_en,
                                bus.o_dunit_reset_pc, bus.o_dunit_w_mem}, 64'd0);
    check("midload_reset_bus", {bus.o_dunit_addr, bus.o_dunit_data_if}, 64'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("midload_no_ack", 64'(tx_cnt - base_tx), 64'd0);
    base_ce = ce_cnt;
    exp_tx.push_back(8'h4B);
    send_rx(8'h53);
    wait_drain(200, "drain_step_after_reset");
    check("step_after_reset_ce", 64'(ce_cnt - base_ce), 64'd1);

    // 2: load three words
    base_wr = wr_cnt; base_ce = ce_cnt; viol = 0;
    for (int w = 0; w < 3; w++) exp_wr.push_back({30'd0, w[1:0], 2'b00, ld_words[w]});
    exp_tx.push_back(8'h4B);
    send_rx(8'h4C); if (!last_rpc || last_ce) viol++;
    send_rx(8'd3);  if (!last_rpc || last_ce) viol++;
    for (int w = 0; w < 3; w++) begin
      for (int b = 0; b < 4; b++) begin
        send_rx(ld_words[w][31-8*b -: 8]);
        if (!last_rpc || last_ce) viol++;
      end
    end
    wait_drain(200, "drain_load");
    check("load_rpc_viol", 64'(viol), 64'd0);
    check("load_wr_cycles", 64'(wr_cnt - base_wr), 64'd3);
    check("load_ce", 64'(ce_cnt - base_ce), 64'd0);

    // Load with N=0: ack, no writes
    base_wr = wr_cnt;
    exp_tx.push_back(8'h4B);
    send_rx(8'h4C); send_rx(8'd0);
    wait_drain(200, "drain_load0");
    check("load0_wr_cycles", 64'(wr_cnt - base_wr), 64'd0);

    // 3: PC reset then three steps
    base_rpc = rpc_cnt; base_tx = tx_cnt;
    exp_tx.push_back(8'h4B);
    send_rx(8'h50);
    wait_drain(200, "drain_pc");
    check("pc_rst_cycles", 64'(rpc_cnt - base_rpc), 64'd1);
    base_ce = ce_cnt;
    for (int s = 0; s < 3; s++) begin
      exp_tx.push_back(8'h4B);
      send_rx(8'h53);
      wait_drain(200, "drain_step");
    end
    check("step_ce_cycles", 64'(ce_cnt - base_ce), 64'd3);
    check("step_ack_count", 64'(tx_cnt - base_tx), 64'd4);

    // 4a: run, halt after 7 enabled cycles
    base_ce = ce_cnt; guard = 0;
    exp_tx.push_back(8'h4B);
    send_rx(8'h52);
    while (((ce_cnt - base_ce) < 7) && (guard < 100)) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("run_reach_7", 64'(ce_cnt - base_ce), 64'd7);
    bus.i_halt = 1'b1;
    wait_drain(200, "drain_run_halt");
    bus.i_halt = 1'b0;
    check("run_halt_ce", 64'(ce_cnt - base_ce), 64'd7);

    // 4b: run to timeout
    base_ce = ce_cnt;
    exp_tx.push_back(8'h54);
    send_rx(8'h52);
    wait_drain(3000, "drain_run_timeout");
    check("run_timeout_ce", 64'(ce_cnt - base_ce), 64'd1024);

    // 5/6: dump with slow TX; bytes sent mid-dump must be dropped
    tx_delay = 50;
    base_tx = tx_cnt; base_ce = ce_cnt; base_wr = wr_cnt;
    for (int r = 0; r < 32; r++) begin
      logic [31:0] v;
      v = 32'h0000_0100 + 32'(r);
      for (int b = 0; b < 4; b++) exp_tx.push_back(v[31-8*b -: 8]);
    end
    for (int m = 0; m < 16; m++) begin
      logic [31:0] v;
      v = 32'hA000_0000 + 32'(m);
      for (int b = 0; b < 4; b++) exp_tx.push_back(v[31-8*b -: 8]);
    end
    exp_tx.push_back(8'h4B);
    send_rx(8'h44);
    repeat (30) @(negedge clk);
    send_rx(8'h53); send_rx(8'h4C); send_rx(8'h7A);
    wait_drain(20000, "drain_dump");
    check("dump_byte_count", 64'(tx_cnt - base_tx), 64'd193);
    check("dump_ce", 64'(ce_cnt - base_ce), 64'd0);
    check("dump_wr", 64'(wr_cnt - base_wr), 64'd0);
    tx_delay = 3;

    // 6: unknown command
    base_tx = tx_cnt;
    exp_tx.push_back(8'h3F);
    send_rx(8'h7A);
    wait_drain(200, "drain_unknown");
    repeat (10) @(negedge clk);
    check("unknown_byte_count", 64'(tx_cnt - base_tx), 64'd1);
    check("imem_queue_empty", 64'(exp_wr.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
